// File: rtl/rv_wb_pkg.sv
// ============================================================================
// Module : rv_wb_pkg
// Brief  : Shared types and constants for the register write-back controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    localparam logic [WB_ADDR_W-1:0] REG_X0 = '0;

    // A cleared vld marks a slot that still occupies the FIFO but must not be written
    typedef struct packed {
        logic                 vld;
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// Module : wb_fifo
// Brief  : In-order load FIFO with per-entry kill-by-rd and youngest-match search.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fifo
    import rv_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_i,
    input  wb_entry_t                 push_entry_i,
    input  logic                      pop_i,
    input  logic                      kill_i,
    input  logic [WB_ADDR_W-1:0]      kill_rd_i,
    input  logic [WB_ADDR_W-1:0]      srch_rd1_i,
    input  logic [WB_ADDR_W-1:0]      srch_rd2_i,
    output wb_entry_t                 srch1_o,
    output wb_entry_t                 srch2_o,
    output wb_entry_t                 head_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic [$clog2(DEPTH):0]    vld_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] w_rd_idx;
    logic [PTR_W-1:0] w_wr_idx;

    assign w_rd_idx = rd_ptr_q[PTR_W-1:0];
    assign w_wr_idx = wr_ptr_q[PTR_W-1:0];
    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign full_o   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head_o   = mem_q[w_rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_i && mem_q[i].vld && (mem_q[i].rd == kill_rd_i)) begin
                    mem_q[i].vld <= 1'b0;
                end
            end
            // Popped slots drop vld so vld alone identifies live, occupied entries
            if (pop_i) begin
                mem_q[w_rd_idx].vld <= 1'b0;
                rd_ptr_q            <= rd_ptr_q + 1'b1;
            end
            if (push_i) begin
                mem_q[w_wr_idx] <= push_entry_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
        end
    end

    // Walk oldest to youngest so the last match found is the youngest one
    function automatic wb_entry_t find_youngest(input logic [WB_ADDR_W-1:0] q);
        wb_entry_t        r;
        logic [PTR_W-1:0] idx;
        r = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = w_rd_idx + PTR_W'(k);
            if ((q != REG_X0) && mem_q[idx].vld && (mem_q[idx].rd == q)) begin
                r = mem_q[idx];
            end
        end
        return r;
    endfunction

    always_comb begin
        srch1_o   = find_youngest(srch_rd1_i);
        srch2_o   = find_youngest(srch_rd2_i);
        vld_cnt_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            vld_cnt_o = vld_cnt_o + (PTR_W+1)'(mem_q[i].vld);
        end
    end

endmodule

`default_nettype wire

// File: rtl/reg_wb_ctrl.sv
// ============================================================================
// Module : reg_wb_ctrl
// Brief  : Write-back arbiter merging ALU and load results into reg_file's write port.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_wb_ctrl
    import rv_wb_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_W,
    parameter int ADDR_WIDTH = WB_ADDR_W,
    parameter int DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alu_valid,
    input  logic [ADDR_WIDTH-1:0]  alu_rd,
    input  logic [DATA_WIDTH-1:0]  alu_data,
    input  logic                   lsu_valid,
    output logic                   lsu_ready,
    input  logic [ADDR_WIDTH-1:0]  lsu_rd,
    input  logic [DATA_WIDTH-1:0]  lsu_data,
    output logic                   wr_en,
    output logic [ADDR_WIDTH-1:0]  addr_wr,
    output logic [DATA_WIDTH-1:0]  data_wr,
    input  logic [ADDR_WIDTH-1:0]  byp_addr1,
    output logic                   byp_hit1,
    output logic [DATA_WIDTH-1:0]  byp_data1,
    input  logic [ADDR_WIDTH-1:0]  byp_addr2,
    output logic                   byp_hit2,
    output logic [DATA_WIDTH-1:0]  byp_data2,
    output logic [$clog2(DEPTH):0] pend_cnt
);

    logic                  wr_en_q,   wr_en_d;
    logic [ADDR_WIDTH-1:0] addr_wr_q, addr_wr_d;
    logic [DATA_WIDTH-1:0] data_wr_q, data_wr_d;

    logic      w_alu_wr;
    logic      w_ld_live;
    logic      w_pop;
    logic      w_direct;
    logic      w_push;
    logic      w_empty;
    logic      w_full;
    wb_entry_t w_head;
    wb_entry_t w_srch1;
    wb_entry_t w_srch2;
    wb_entry_t w_push_entry;

    assign lsu_ready = !w_full;
    assign w_alu_wr  = alu_valid && (alu_rd != REG_X0);
    // A same-cycle ALU write to the same rd is younger, so the load is dead on arrival
    assign w_ld_live = lsu_valid && lsu_ready && (lsu_rd != REG_X0) &&
                       !(w_alu_wr && (lsu_rd == alu_rd));
    assign w_push    = w_ld_live && !w_direct;

    assign w_push_entry = '{vld: 1'b1, rd: lsu_rd, data: lsu_data};

    always_comb begin
        wr_en_d   = 1'b0;
        addr_wr_d = addr_wr_q;
        data_wr_d = data_wr_q;
        w_pop     = 1'b0;
        w_direct  = 1'b0;
        if (w_alu_wr) begin
            wr_en_d   = 1'b1;
            addr_wr_d = alu_rd;
            data_wr_d = alu_data;
        end else if (!w_empty) begin
            w_pop = 1'b1;
            if (w_head.vld) begin
                wr_en_d   = 1'b1;
                addr_wr_d = w_head.rd;
                data_wr_d = w_head.data;
            end
        end else if (w_ld_live) begin
            w_direct  = 1'b1;
            wr_en_d   = 1'b1;
            addr_wr_d = lsu_rd;
            data_wr_d = lsu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            addr_wr_q <= '0;
            data_wr_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            addr_wr_q <= addr_wr_d;
            data_wr_q <= data_wr_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign addr_wr = addr_wr_q;
    assign data_wr = data_wr_q;

    wb_fifo #(
        .DEPTH        (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (w_push),
        .push_entry_i (w_push_entry),
        .pop_i        (w_pop),
        .kill_i       (w_alu_wr),
        .kill_rd_i    (alu_rd),
        .srch_rd1_i   (byp_addr1),
        .srch_rd2_i   (byp_addr2),
        .srch1_o      (w_srch1),
        .srch2_o      (w_srch2),
        .head_o       (w_head),
        .empty_o      (w_empty),
        .full_o       (w_full),
        .vld_cnt_o    (pend_cnt)
    );

    // FIFO entries are younger than the output stage, so they take priority
    always_comb begin
        byp_hit1  = 1'b0;
        byp_data1 = '0;
        byp_hit2  = 1'b0;
        byp_data2 = '0;
        if (w_srch1.vld) begin
            byp_hit1  = 1'b1;
            byp_data1 = w_srch1.data;
        end else if ((byp_addr1 != REG_X0) && wr_en_q && (addr_wr_q == byp_addr1)) begin
            byp_hit1  = 1'b1;
            byp_data1 = data_wr_q;
        end
        if (w_srch2.vld) begin
            byp_hit2  = 1'b1;
            byp_data2 = w_srch2.data;
        end else if ((byp_addr2 != REG_X0) && wr_en_q && (addr_wr_q == byp_addr2)) begin
            byp_hit2  = 1'b1;
            byp_data2 = data_wr_q;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_wb_ctrl.sv
// ============================================================================
// Module : tb_reg_wb_ctrl
// Brief  : Self-checking bench for reg_wb_ctrl against a queue-based reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_reg_wb_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_valid = 1'b0;
    logic [AW-1:0] alu_rd = '0;
    logic [DW-1:0] alu_data = '0;
    logic          lsu_valid = 1'b0;
    logic          lsu_ready;
    logic [AW-1:0] lsu_rd = '0;
    logic [DW-1:0] lsu_data = '0;
    logic          wr_en;
    logic [AW-1:0] addr_wr;
    logic [DW-1:0] data_wr;
    logic [AW-1:0] byp_addr1 = '0;
    logic          byp_hit1;
    logic [DW-1:0] byp_data1;
    logic [AW-1:0] byp_addr2 = '0;
    logic          byp_hit2;
    logic [DW-1:0] byp_data2;
    logic [2:0]    pend_cnt;

    always #5 clk = ~clk;

    reg_wb_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .wr_en(wr_en), .addr_wr(addr_wr), .data_wr(data_wr),
        .byp_addr1(byp_addr1), .byp_hit1(byp_hit1), .byp_data1(byp_data1),
        .byp_addr2(byp_addr2), .byp_hit2(byp_hit2), .byp_data2(byp_data2),
        .pend_cnt(pend_cnt)
    );

    // Reference model: a program-ordered list of pending loads plus the last write issued
    typedef struct {
        bit          live;
        int unsigned rd;
        logic [31:0] data;
    } pend_t;

    pend_t       mq[$];
    bit          m_en;
    int unsigned m_addr;
    logic [31:0] m_data;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_en   = 1'b0;
        m_addr = 0;
        m_data = '0;
    endtask

    function automatic int model_pending();
        int n = 0;
        foreach (mq[i]) if (mq[i].live) n++;
        return n;
    endfunction

    // Youngest pending load wins; otherwise the write currently on the port
    task automatic model_byp(input int unsigned a, output bit hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != 0) begin
            for (int i = mq.size() - 1; i >= 0 && !hit; i--) begin
                if (mq[i].live && mq[i].rd == a) begin
                    hit = 1'b1;
                    d   = mq[i].data;
                end
            end
            if (!hit && m_en && m_addr == a) begin
                hit = 1'b1;
                d   = m_data;
            end
        end
    endtask

    task automatic model_step();
        bit    accepted;
        bit    alu_w;
        pend_t p;
        accepted = lsu_valid && (mq.size() < DEPTH) && (lsu_rd != 0);
        alu_w    = alu_valid && (alu_rd != 0);
        p.live   = 1'b1;
        p.rd     = lsu_rd;
        p.data   = lsu_data;
        if (alu_w) begin
            foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].live = 1'b0;
            m_en   = 1'b1;
            m_addr = alu_rd;
            m_data = alu_data;
            if (accepted && lsu_rd != alu_rd) mq.push_back(p);
        end else if (mq.size() > 0) begin
            pend_t h;
            h = mq.pop_front();
            m_en = h.live;
            if (h.live) begin
                m_addr = h.rd;
                m_data = h.data;
            end
            if (accepted) mq.push_back(p);
        end else if (accepted) begin
            m_en   = 1'b1;
            m_addr = lsu_rd;
            m_data = lsu_data;
        end else begin
            m_en = 1'b0;
        end
    endtask

    task automatic compare();
        bit          h;
        logic [31:0] d;
        chk("lsu_ready", 32'(lsu_ready), 32'(mq.size() < DEPTH));
        chk("pend_cnt", 32'(pend_cnt), 32'(model_pending()));
        chk("wr_en", 32'(wr_en), 32'(m_en));
        if (m_en) begin
            chk("addr_wr", 32'(addr_wr), 32'(m_addr));
            chk("data_wr", data_wr, m_data);
        end
        model_byp(byp_addr1, h, d);
        chk("byp_hit1", 32'(byp_hit1), 32'(h));
        chk("byp_data1", byp_data1, d);
        model_byp(byp_addr2, h, d);
        chk("byp_hit2", 32'(byp_hit2), 32'(h));
        chk("byp_data2", byp_data2, d);
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic drive(input bit av, input int ar, input logic [31:0] ad,
                         input bit lv, input int lr, input logic [31:0] ld);
        alu_valid = av;
        alu_rd    = AW'(ar);
        alu_data  = ad;
        lsu_valid = lv;
        lsu_rd    = AW'(lr);
        lsu_data  = ld;
    endtask

    task automatic idle();
        drive(0, 0, 32'h0, 0, 0, 32'h0);
    endtask

    typedef struct {
        bit av; int ar; logic [31:0] ad;
        bit lv; int lr; logic [31:0] ld;
        int b1; int b2;
    } vec_t;

    vec_t vecs[10] = '{
        '{0,  0, 32'h00, 1, 12, 32'hC0, 12,  0},
        '{1, 10, 32'hA1, 1, 10, 32'hB1, 10, 12},
        '{1, 13, 32'hD1, 1, 14, 32'hE1, 13, 14},
        '{0,  0, 32'h00, 1, 15, 32'hF1, 14, 15},
        '{0,  0, 32'h00, 1, 14, 32'hE2, 14, 15},
        '{1, 14, 32'hAA, 1, 16, 32'h16, 14, 16},
        '{0,  0, 32'h00, 0,  0, 32'h00, 14, 16},
        '{0,  0, 32'h00, 0,  0, 32'h00, 16, 14},
        '{1,  0, 32'h77, 1,  0, 32'h88, 16,  0},
        '{0,  0, 32'h00, 0,  0, 32'h00,  0, 16}
    };

    initial begin
        model_reset();
        #2;
        chk("rst_wr_en", 32'(wr_en), 32'h0);
        chk("rst_addr_wr", 32'(addr_wr), 32'h0);
        chk("rst_data_wr", data_wr, 32'h0);
        chk("rst_pend_cnt", 32'(pend_cnt), 32'h0);
        chk("rst_lsu_ready", 32'(lsu_ready), 32'h1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // ALU and load in the same cycle: ALU first, load one cycle later
        drive(1, 5, 32'hAAAA, 1, 6, 32'hBBBB);
        step();
        chk("t2_c1_wr_en", 32'(wr_en), 32'h1);
        chk("t2_c1_addr", 32'(addr_wr), 32'd5);
        chk("t2_c1_data", data_wr, 32'hAAAA);
        idle();
        step();
        chk("t2_c2_wr_en", 32'(wr_en), 32'h1);
        chk("t2_c2_addr", 32'(addr_wr), 32'd6);
        chk("t2_c2_data", data_wr, 32'hBBBB);
        step();

        // Fill the FIFO behind a busy ALU, then drain in order
        for (int i = 1; i <= 4; i++) begin
            drive(1, 16 + i, 32'h100 + i, 1, i, 32'h1000 + i);
            step();
        end
        chk("t3_pend_full", 32'(pend_cnt), 32'd4);
        chk("t3_ready_full", 32'(lsu_ready), 32'h0);
        for (int i = 0; i < 2; i++) begin
            drive(1, 21 + i, 32'h200 + i, 1, 8, 32'h8888);
            step();
            chk("t3_ready_busy", 32'(lsu_ready), 32'h0);
        end
        idle();
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("t3_drain_addr", 32'(addr_wr), 32'(i));
            chk("t3_drain_data", data_wr, 32'h1000 + i);
        end
        chk("t3_pend_empty", 32'(pend_cnt), 32'd0);
        step();

        // WAW kill of a queued load
        drive(1, 3, 32'h33, 1, 7, 32'h1111);
        step();
        drive(1, 7, 32'h2222, 0, 0, 32'h0);
        step();
        chk("t4_addr", 32'(addr_wr), 32'd7);
        chk("t4_data", data_wr, 32'h2222);
        chk("t4_pend", 32'(pend_cnt), 32'd0);
        idle();
        step();
        chk("t4_killed_pop", 32'(wr_en), 32'h0);
        step();

        // Bypass picks the youngest queued value; x0 never hits
        drive(1, 3, 32'h5, 1, 9, 32'h10);
        step();
        drive(1, 4, 32'h6, 1, 9, 32'h20);
        step();
        byp_addr1 = 5'd9;
        byp_addr2 = 5'd0;
        #1;
        chk("t5_hit1", 32'(byp_hit1), 32'h1);
        chk("t5_data1", byp_data1, 32'h20);
        chk("t5_hit2", 32'(byp_hit2), 32'h0);
        chk("t5_data2", byp_data2, 32'h0);
        idle();
        step();
        step();
        chk("t5_outstage_hit", 32'(byp_hit1), 32'h1);
        chk("t5_outstage_data", byp_data1, 32'h20);
        step();

        // x0 results are never written
        drive(1, 0, 32'h77, 1, 0, 32'h88);
        step();
        chk("t6_wr_en", 32'(wr_en), 32'h0);
        chk("t6_pend", 32'(pend_cnt), 32'd0);
        idle();
        step();

        foreach (vecs[i]) begin
            drive(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].lv, vecs[i].lr, vecs[i].ld);
            byp_addr1 = AW'(vecs[i].b1);
            byp_addr2 = AW'(vecs[i].b2);
            step();
        end
        idle();
        step();

        // Asynchronous reset with three loads queued
        for (int i = 0; i < 3; i++) begin
            drive(1, 20 + i, 32'h300 + i, 1, 11 + i, 32'h400 + i);
            step();
        end
        chk("t1_pend_before", 32'(pend_cnt), 32'd3);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t1_wr_en", 32'(wr_en), 32'h0);
        chk("t1_pend", 32'(pend_cnt), 32'h0);
        chk("t1_ready", 32'(lsu_ready), 32'h1);
        chk("t1_addr", 32'(addr_wr), 32'h0);
        chk("t1_data", data_wr, 32'h0);
        idle();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
